// File: rtl/pool_relu_stream.sv
// Streaming 2x2/stride-2 max-pool with optional ReLU over valid/ready handshakes.
// One line buffer row of horizontal maxima; single-stage output register.
module pool_relu_stream #(
    parameter int DATA_W  = 32,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int CH      = 1,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int LB_DEPTH = (IMG_W / 2) * CH;
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1;
    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [CH_W-1:0]  ch_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;

    logic signed [DATA_W-1:0] hold    [CH];
    logic signed [DATA_W-1:0] linebuf [LB_DEPTH];

    logic                     beat;
    logic                     ch_wrap, col_wrap, row_wrap;
    logic                     col_odd, row_odd;
    logic                     completes, frame_end;
    logic [LB_AW-1:0]         lb_idx;
    logic signed [DATA_W-1:0] hold_rd, lb_rd, hmax, pmax, result;

    // Stalls whenever a result is held and downstream is not taking it.
    assign in_ready  = !out_valid || out_ready;
    assign beat      = in_valid && in_ready;

    assign ch_wrap   = (ch_cnt  == CH_W'(CH - 1));
    assign col_wrap  = (col_cnt == COL_W'(IMG_W - 1));
    assign row_wrap  = (row_cnt == ROW_W'(IMG_H - 1));
    assign col_odd   = col_cnt[0];
    assign row_odd   = row_cnt[0];
    assign completes = col_odd && row_odd;
    assign frame_end = ch_wrap && col_wrap && row_wrap;
    assign lb_idx    = LB_AW'((int'(col_cnt) / 2) * CH + int'(ch_cnt));

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        hold_rd = hold[ch_cnt];
        lb_rd   = linebuf[lb_idx];
        hmax    = (hold_rd > in_data) ? hold_rd : in_data;
        pmax    = (lb_rd > hmax) ? lb_rd : hmax;
        result  = pmax;
        if (RELU_EN != 0 && pmax < 0) begin
            result = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ch_cnt    <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (beat) begin
                if (ch_wrap) begin
                    ch_cnt <= '0;
                    if (col_wrap) begin
                        col_cnt <= '0;
                        row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end else begin
                    ch_cnt <= ch_cnt + 1'b1;
                end
                if (completes) begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                    out_last  <= frame_end;
                end
            end
        end
    end

    // NOTE: hold and linebuf are deliberately not reset; each entry is written before it is read.
    always_ff @(posedge clk) begin
        if (beat) begin
            if (!col_odd) begin
                hold[ch_cnt] <= in_data;
            end else if (!row_odd) begin
                linebuf[lb_idx] <= hmax;
            end
        end
    end

endmodule
